// File: rtl/empaquetador_escritura_mem.sv
// Packs a stream of 8-bit filtered pixels into little-endian memory words and
// issues one held write per word to the off-chip port, from a base address.
module empaquetador_escritura_mem #(
  parameter int BITS_DIRECCION_MEM = 14,
  parameter int BITS_MEMORY_DATA   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_resultado,
  input  logic [BITS_DIRECCION_MEM-1:0] escrituras_totales_mem,
  input  logic [7:0]                    pixel_resultado,
  input  logic                          pixel_valido,
  input  logic                          escritura_mem_completada,
  output logic                          listo_para_pixel,
  output logic                          write_mem,
  output logic [BITS_DIRECCION_MEM-1:0] address_mem,
  output logic [BITS_MEMORY_DATA-1:0]   write_data_mem,
  output logic                          escritura_finalizada
);

  localparam logic [BITS_DIRECCION_MEM-1:0] UNO = 1;

  typedef enum logic [1:0] {IDLE, ACTIVO, FIN} estado_t;

  estado_t                        estado_q, estado_d;
  logic [BITS_DIRECCION_MEM-1:0]  base_q, total_q;
  logic [BITS_DIRECCION_MEM-1:0]  aceptadas_q, completadas_q;
  logic [1:0]                     npix_q;
  logic                           acc_lleno_q;
  logic [BITS_MEMORY_DATA-1:0]    acc_q, hold_q;
  logic                           write_q;

  logic                           arranque, listo, acepta, libera, hold_libre;
  logic                           palabra_nueva, carga_hold, ultima;
  logic [BITS_DIRECCION_MEM-1:0]  completadas_inc;
  logic [BITS_MEMORY_DATA-1:0]    acc_con_pixel;

  assign arranque        = iniciar && (estado_q != ACTIVO);
  assign listo           = (estado_q == ACTIVO) && !acc_lleno_q && (aceptadas_q < total_q);
  assign acepta          = listo && pixel_valido;
  assign libera          = write_q && escritura_mem_completada;
  assign hold_libre      = !write_q || libera;
  assign palabra_nueva   = acepta && (npix_q == 2'd3);
  // A parked full word or a word completing now both go to the hold register
  // as soon as it is empty or being released on this edge.
  assign carga_hold      = hold_libre && (acc_lleno_q || palabra_nueva);
  assign completadas_inc = completadas_q + UNO;
  assign ultima          = libera && (completadas_inc == total_q);

  always_comb begin
    acc_con_pixel = acc_q;
    acc_con_pixel[{npix_q, 3'b000} +: 8] = pixel_resultado;
  end

  always_ff @(posedge clk) begin
    if (reset) estado_q <= IDLE;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE, FIN: if (iniciar) estado_d = (escrituras_totales_mem == '0) ? FIN : ACTIVO;
      ACTIVO:    if (ultima) estado_d = FIN;
      default:   estado_d = IDLE;
    endcase
  end

  always_comb begin
    listo_para_pixel     = listo;
    write_mem            = write_q;
    address_mem          = base_q + completadas_q;
    write_data_mem       = hold_q;
    escritura_finalizada = (estado_q == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q        <= '0;
      total_q       <= '0;
      aceptadas_q   <= '0;
      completadas_q <= '0;
      npix_q        <= '0;
      acc_lleno_q   <= 1'b0;
      acc_q         <= '0;
      hold_q        <= '0;
      write_q       <= 1'b0;
    end else if (arranque) begin
      base_q        <= direccion_mem_inicio_resultado;
      total_q       <= escrituras_totales_mem;
      aceptadas_q   <= '0;
      completadas_q <= '0;
      npix_q        <= '0;
      acc_lleno_q   <= 1'b0;
      acc_q         <= '0;
      write_q       <= 1'b0;
    end else begin
      if (acepta) begin
        npix_q <= npix_q + 2'd1;
        acc_q  <= acc_con_pixel;
      end
      if (palabra_nueva) aceptadas_q <= aceptadas_q + UNO;
      if (carga_hold) begin
        hold_q      <= acc_lleno_q ? acc_q : acc_con_pixel;
        acc_lleno_q <= 1'b0;
      end else if (palabra_nueva) begin
        acc_lleno_q <= 1'b1;
      end
      if (carga_hold)  write_q <= 1'b1;
      else if (libera) write_q <= 1'b0;
      if (libera) completadas_q <= completadas_inc;
    end
  end

endmodule

// File: tb/tb_empaquetador_escritura_mem.sv
// Bench for the pixel-to-word write packer: table of transfers checked against
// a queue-based model of the expected word stream, plus reset corner cases.
module tb_empaquetador_escritura_mem;

  logic        clk = 1'b0;
  logic        reset, iniciar, pixel_valido, escritura_mem_completada;
  logic [13:0] direccion_mem_inicio_resultado, escrituras_totales_mem;
  logic [7:0]  pixel_resultado;
  logic        listo_para_pixel, write_mem, escritura_finalizada;
  logic [13:0] address_mem;
  logic [31:0] write_data_mem;

  empaquetador_escritura_mem #(.BITS_DIRECCION_MEM(14), .BITS_MEMORY_DATA(32)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .direccion_mem_inicio_resultado(direccion_mem_inicio_resultado),
    .escrituras_totales_mem(escrituras_totales_mem),
    .pixel_resultado(pixel_resultado), .pixel_valido(pixel_valido),
    .escritura_mem_completada(escritura_mem_completada),
    .listo_para_pixel(listo_para_pixel), .write_mem(write_mem),
    .address_mem(address_mem), .write_data_mem(write_data_mem),
    .escritura_finalizada(escritura_finalizada)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] base;
    int          total;
    int          delay;      // -1: random acknowledge timing
    bit          rand_mode;  // random pixels, gaps, spurious acks, stray iniciar
    logic [31:0] exp_first;  // first word when pixels are 0x11,0x22,...
    int          exp_stall;  // accepted pixels when listo first drops, 0 = n/a
    logic [13:0] exp_last;
  } vec_t;

  int total_n = 0;
  int bad_n   = 0;
  logic [7:0] pix_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] palabra(input int k);
    if (pix_q.size() < 4 * (k + 1)) return 32'hxxxxxxxx;
    return {pix_q[4*k+3], pix_q[4*k+2], pix_q[4*k+1], pix_q[4*k]};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write"}, {31'd0, write_mem}, 32'd0);
    chk({tag, "_listo"}, {31'd0, listo_para_pixel}, 32'd0);
    chk({tag, "_fin"},   {31'd0, escritura_finalizada}, 32'd0);
    chk({tag, "_addr"},  {18'd0, address_mem}, 32'd0);
    chk({tag, "_data"},  write_data_mem, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v);
    int acc_n, wr, waited, stall;
    bit b2b_pend, stab_pend, pv, a, acc_ok;
    logic [13:0] prev_addr, last_addr, exp_addr;
    logic [31:0] prev_data;
    pix_q.delete();
    @(negedge clk);
    iniciar = 1'b1;
    direccion_mem_inicio_resultado = v.base;
    escrituras_totales_mem = 14'(v.total);
    pixel_valido = 1'b0;
    escritura_mem_completada = 1'b0;
    @(negedge clk);
    iniciar = 1'b0;
    if (v.total == 0) begin
      chk("zero_fin", {31'd0, escritura_finalizada}, 32'd1);
      chk("zero_listo", {31'd0, listo_para_pixel}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        chk("zero_nowrite", {31'd0, write_mem}, 32'd0);
        @(negedge clk);
      end
      return;
    end
    acc_n = 0; wr = 0; waited = 0; stall = -1;
    b2b_pend = 0; stab_pend = 0; last_addr = '0;
    prev_addr = '0; prev_data = '0;
    for (int cyc = 0; cyc < 3000 && !escritura_finalizada; cyc++) begin
      if (b2b_pend) begin
        chk("b2b_write", {31'd0, write_mem}, 32'd1);
        chk("b2b_addr", {18'd0, address_mem}, {18'd0, 14'(v.base + 14'(wr))});
        b2b_pend = 0;
      end
      if (stab_pend) begin
        chk("hold_write", {31'd0, write_mem}, 32'd1);
        chk("hold_addr", {18'd0, address_mem}, {18'd0, prev_addr});
        chk("hold_data", write_data_mem, prev_data);
        stab_pend = 0;
      end
      if (listo_para_pixel) begin
        acc_ok = (acc_n - 4 * wr <= 7) && (acc_n < 4 * v.total);
        chk("listo_allowed", {31'd0, acc_ok}, 32'd1);
      end else if (stall < 0 && acc_n < 4 * v.total) begin
        stall = acc_n;
      end
      iniciar = v.rand_mode && (cyc == 7);
      direccion_mem_inicio_resultado = iniciar ? ~v.base : v.base;
      escrituras_totales_mem = iniciar ? 14'd1 : 14'(v.total);
      pv = v.rand_mode ? ($urandom_range(3) != 0) : 1'b1;
      pixel_valido = pv;
      pixel_resultado = v.rand_mode ? 8'($urandom) : 8'((acc_n + 1) * 17);
      if (pv && listo_para_pixel) begin
        pix_q.push_back(pixel_resultado);
        acc_n++;
      end
      if (write_mem) a = (v.delay < 0) ? ($urandom_range(2) == 0) : (waited >= v.delay);
      else           a = v.rand_mode ? 1'($urandom_range(1)) : 1'b0;
      escritura_mem_completada = a;
      if (write_mem && a) begin
        exp_addr = 14'(v.base + 14'(wr));
        chk("wr_addr", {18'd0, address_mem}, {18'd0, exp_addr});
        chk("wr_data", write_data_mem, (wr < v.total) ? palabra(wr) : 32'hxxxxxxxx);
        if (!v.rand_mode && wr == 0) chk("wr_first", write_data_mem, v.exp_first);
        last_addr = address_mem;
        wr++;
        waited = 0;
        if (wr < v.total && acc_n >= 4 * (wr + 1)) b2b_pend = 1;
      end else if (write_mem) begin
        waited++;
        stab_pend = 1;
        prev_addr = address_mem;
        prev_data = write_data_mem;
      end
      @(negedge clk);
    end
    iniciar = 1'b0;
    pixel_valido = 1'b0;
    escritura_mem_completada = 1'b0;
    chk("fin_reached", {31'd0, escritura_finalizada}, 32'd1);
    chk("n_writes", wr, v.total);
    chk("n_pixels", acc_n, 4 * v.total);
    chk("last_addr", {18'd0, last_addr}, {18'd0, v.exp_last});
    if (v.exp_stall != 0) chk("stall_at", stall, v.exp_stall);
    @(negedge clk);
    chk("fin_hold", {31'd0, escritura_finalizada}, 32'd1);
    chk("fin_write", {31'd0, write_mem}, 32'd0);
    chk("fin_listo", {31'd0, listo_para_pixel}, 32'd0);
  endtask

  vec_t tabla[7];
  vec_t extra;

  initial begin
    tabla[0] = '{14'h0100, 1,  1, 1'b0, 32'h44332211, 0, 14'h0100};
    tabla[1] = '{14'h0200, 3, 10, 1'b0, 32'h44332211, 8, 14'h0202};
    tabla[2] = '{14'h3FFF, 2,  0, 1'b1, 32'h0,        0, 14'h0000};
    tabla[3] = '{14'h1234, 0,  0, 1'b0, 32'h0,        0, 14'h0000};
    tabla[4] = '{14'h0050, 20, -1, 1'b1, 32'h0,       0, 14'h0063};
    tabla[5] = '{14'h3FF0, 40, 0, 1'b0, 32'h44332211, 0, 14'h0017};
    tabla[6] = '{14'h0A00, 6,  3, 1'b0, 32'h44332211, 0, 14'h0A05};

    reset = 1'b1; iniciar = 1'b0; pixel_valido = 1'b0;
    escritura_mem_completada = 1'b0; pixel_resultado = '0;
    direccion_mem_inicio_resultado = '0; escrituras_totales_mem = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst0");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_xfer(tabla[i]);

    // Reset in the middle of an outstanding write, together with iniciar.
    @(negedge clk);
    iniciar = 1'b1;
    direccion_mem_inicio_resultado = 14'h0200;
    escrituras_totales_mem = 14'd4;
    @(negedge clk);
    iniciar = 1'b0;
    pixel_valido = 1'b1;
    for (int i = 0; i < 50 && !write_mem; i++) begin
      pixel_resultado = 8'($urandom);
      @(negedge clk);
    end
    chk("pre_rst_write", {31'd0, write_mem}, 32'd1);
    pixel_valido = 1'b0;
    reset = 1'b1;
    iniciar = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(negedge clk);
    chk_all_zero("rst_iniciar");
    reset = 1'b0;
    iniciar = 1'b0;
    extra = '{14'h0010, 2, 2, 1'b0, 32'h44332211, 0, 14'h0011};
    run_xfer(extra);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
